// File: rtl/qoa_pkg.sv
// Shared constants and types for the QOA slice decode path.
// Scalefactor and dequant multiplier tables match the C reference decoder.
package qoa_pkg;

    localparam int QOA_SLICE_LEN   = 20;
    localparam int QOA_SLICE_BYTES = 8;

    localparam logic [11:0] QOA_SF_TAB [16] = '{
        12'd1,    12'd7,    12'd21,   12'd45,   12'd84,   12'd138,  12'd211,  12'd304,
        12'd421,  12'd562,  12'd731,  12'd928,  12'd1157, 12'd1419, 12'd1715, 12'd2048
    };

    // Quarter-unit multipliers {0.75, 2.5, 4.5, 7} for q>>1
    localparam logic [4:0] QOA_DQ_K [4] = '{5'd3, 5'd10, 5'd18, 5'd28};

    typedef logic signed [15:0] residual_t;

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

endpackage

// File: rtl/qoa_dequant.sv
// Combinational dequantiser: (scalefactor index, 3-bit code) -> signed residual.
// Rounds half away from zero; magnitude never exceeds 14336, so no saturation.
module qoa_dequant
    import qoa_pkg::*;
(
    input  logic [3:0] sf_idx,
    input  logic [2:0] q,
    output residual_t  res
);

    logic [16:0] prod;

    always_comb begin
        prod = 17'(QOA_SF_TAB[sf_idx]) * 17'(QOA_DQ_K[q[2:1]]);
        res  = residual_t'((prod + 17'd2) >> 2);
        if (q[0]) begin
            res = -res;
        end
    end

endmodule

// File: rtl/qoa_slice_unpack.sv
// Gathers one 64-bit QOA slice from a byte stream and emits its 20 dequantised
// residuals on a valid/ready stream. Load and emit never overlap.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_LOAD | accepting slice bytes, MSB first; byte_ready high
//   ST_EMIT | presenting residual idx of the held slice; res_valid high
module qoa_slice_unpack
    import qoa_pkg::*;
#(
    parameter int OUT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       byte_in,
    input  logic             byte_valid,
    output logic             byte_ready,
    output logic [OUT_W-1:0] res_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_last,
    output logic             busy
);

    localparam logic [2:0] CNT_LAST = 3'(QOA_SLICE_BYTES - 1);
    localparam logic [4:0] IDX_LAST = 5'(QOA_SLICE_LEN - 1);

    state_t      state;
    state_t      state_nxt;
    logic [63:0] slice_reg;
    logic [2:0]  cnt;
    logic [4:0]  idx;
    logic        byte_acc;
    logic        res_acc;
    logic [2:0]  q_arr [QOA_SLICE_LEN];
    logic [2:0]  q_cur;
    residual_t   dq_res;

    assign byte_acc = byte_valid && byte_ready;
    assign res_acc  = res_valid && res_ready;
    assign busy     = (state == ST_EMIT) || (cnt != 3'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_LOAD: if (byte_acc && cnt == CNT_LAST) state_nxt = ST_EMIT;
            ST_EMIT: if (res_acc && idx == IDX_LAST) state_nxt = ST_LOAD;
            default: state_nxt = ST_LOAD;
        endcase
    end

    always_comb begin
        byte_ready = 1'b0;
        res_valid  = 1'b0;
        res_last   = 1'b0;
        res_out    = '0;
        case (state)
            ST_LOAD: byte_ready = 1'b1;
            ST_EMIT: begin
                res_valid = 1'b1;
                res_last  = (idx == IDX_LAST);
                res_out   = OUT_W'(dq_res);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slice_reg <= '0;
            cnt       <= '0;
            idx       <= '0;
        end else begin
            if (byte_acc) begin
                slice_reg <= {slice_reg[55:0], byte_in};
                cnt       <= (cnt == CNT_LAST) ? 3'd0 : cnt + 3'd1;
                idx       <= '0;
            end
            if (res_acc) begin
                idx <= (idx == IDX_LAST) ? 5'd0 : idx + 5'd1;
            end
        end
    end

    // Residual k sits directly below the 4-bit scalefactor, 3 bits each
    always_comb begin
        for (int k = 0; k < QOA_SLICE_LEN; k++) begin
            q_arr[k] = slice_reg[59 - 3*k -: 3];
        end
        q_cur = q_arr[idx];
    end

    qoa_dequant u_dequant (
        .sf_idx (slice_reg[63:60]),
        .q      (q_cur),
        .res    (dq_res)
    );

endmodule

// File: tb/tb_qoa_slice_unpack.sv
// Bench for qoa_slice_unpack: directed slices, randomized gaps/stalls and a
// mid-slice reset, all checked against a real-arithmetic reference model.
module tb_qoa_slice_unpack;

    logic        clk;
    logic        rst;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic [15:0] res_out;
    logic        res_valid;
    logic        res_ready;
    logic        res_last;
    logic        busy;

    logic [3:0]  dq_sf;
    logic [2:0]  dq_q;
    logic signed [15:0] dq_res;

    qoa_slice_unpack #(.OUT_W(16)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .res_out    (res_out),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_last   (res_last),
        .busy       (busy)
    );

    qoa_dequant u_dq (
        .sf_idx (dq_sf),
        .q      (dq_q),
        .res    (dq_res)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int errs    = 0;
    int cyc     = 0;
    int beats_seen = 0;
    int beat_in_slice = 0;
    int br_low = 0;
    int first_beat_cyc = 0;
    int last_byte_cyc = 0;
    bit stall = 1'b0;
    bit hold_valid = 1'b0;
    logic [15:0] held_res;
    logic        held_last;
    int exp_q[$];

    int  sf_ref[16]  = '{1, 7, 21, 45, 84, 138, 211, 304, 421, 562, 731, 928, 1157, 1419, 1715, 2048};
    real dq_mult[4]  = '{0.75, 2.5, 4.5, 7.0};

    task automatic chk(input string tag, input longint obs, input longint exp);
        vectors++;
        if (obs != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int ref_res(input int sfi, input int q);
        int m;
        m = int'(sf_ref[sfi] * dq_mult[q >> 1]);
        return (q & 1) ? -m : m;
    endfunction

    function automatic void push_slice(input logic [63:0] s);
        int sfi;
        int q;
        sfi = int'(s[63:60]);
        for (int k = 0; k < 20; k++) begin
            q = int'((s >> (57 - 3*k)) & 64'h7);
            exp_q.push_back(ref_res(sfi, q));
        end
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            res_ready = stall ? ($urandom_range(2, 0) != 0) : 1'b1;
        end
    end

    // Output monitor: scoreboard, res_last position, stability under stall
    always @(negedge clk) begin
        if (rst) begin
            beat_in_slice = 0;
            hold_valid    = 1'b0;
        end else begin
            if (!byte_ready) br_low++;
            if (hold_valid) begin
                chk("hold_valid", res_valid, 1);
                chk("hold_res", res_out, held_res);
                chk("hold_last", res_last, held_last);
            end
            hold_valid = 1'b0;
            if (res_valid) begin
                if (res_ready) begin
                    if (beat_in_slice == 0) first_beat_cyc = cyc;
                    if (exp_q.size() == 0) begin
                        chk("extra_beat", 1, 0);
                    end else begin
                        chk("res", $signed(res_out), exp_q.pop_front());
                    end
                    chk("last", res_last, (beat_in_slice == 19));
                    beat_in_slice = (beat_in_slice == 19) ? 0 : beat_in_slice + 1;
                    beats_seen++;
                end else begin
                    hold_valid = 1'b1;
                    held_res   = res_out;
                    held_last  = res_last;
                end
            end
        end
    end

    task automatic send_slice(input logic [63:0] s, input int max_gap);
        bit ok;
        int n;
        push_slice(s);
        for (int i = 0; i < 8; i++) begin
            if (max_gap > 0) begin
                repeat ($urandom_range(max_gap, 0)) begin
                    byte_valid = 1'b0;
                    @(posedge clk);
                    #1;
                end
            end
            byte_in    = s[63 - 8*i -: 8];
            byte_valid = 1'b1;
            n = 0;
            do begin
                @(negedge clk);
                ok = byte_ready;
                n++;
            end while (!ok && n < 500);
            if (!ok) chk("byte_timeout", 0, 1);
            if (i == 7) last_byte_cyc = cyc;
            @(posedge clk);
            #1;
        end
        byte_valid = 1'b0;
    endtask

    task automatic wait_beats(input int target);
        for (int n = 0; n < 3000 && beats_seen < target; n++) begin
            @(posedge clk);
            #2;
        end
        chk("beat_timeout", beats_seen >= target, 1);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_byte_ready"}, byte_ready, 1);
        chk({tag, "_res_valid"}, res_valid, 0);
        chk({tag, "_res_last"}, res_last, 0);
        chk({tag, "_res_out"}, res_out, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        logic [63:0] s;
        int base;
        rst        = 1'b1;
        byte_valid = 1'b0;
        byte_in    = 8'h00;
        res_ready  = 1'b1;

        for (int sfi = 0; sfi < 16; sfi++) begin
            for (int q = 0; q < 8; q++) begin
                dq_sf = 4'(sfi);
                dq_q  = 3'(q);
                #1;
                chk("dequant", dq_res, ref_res(sfi, q));
            end
        end

        repeat (2) @(posedge clk);
        #1;
        check_idle("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // All-zero slice, free-running output: latency and byte_ready window
        br_low = 0;
        base = beats_seen;
        send_slice(64'h0, 0);
        wait_beats(base + 20);
        repeat (3) @(posedge clk);
        #1;
        chk("first_beat_latency", first_beat_cyc - last_byte_cyc, 1);
        chk("byte_ready_low_cycles", br_low, 20);
        chk("queue_empty_zero", exp_q.size(), 0);
        check_idle("after_zero");

        base = beats_seen;
        send_slice(64'hFE00_0000_0000_0000, 0);
        send_slice(64'h1400_0000_0000_0000, 0);
        s = 64'h1 << 60;
        for (int k = 0; k < 8; k++) s = s | (64'(k) << (57 - 3*k));
        send_slice(s, 0);
        wait_beats(base + 60);
        chk("queue_empty_directed", exp_q.size(), 0);

        // Random slices with byte gaps and output stalls
        stall = 1'b1;
        base = beats_seen;
        for (int n = 0; n < 3; n++) begin
            s = {$urandom(), $urandom()};
            send_slice(s, 3);
        end
        wait_beats(base + 60);
        chk("queue_empty_random", exp_q.size(), 0);
        stall = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset mid-emit after 7 beats, then a fresh slice
        base = beats_seen;
        send_slice({$urandom(), $urandom()}, 0);
        wait_beats(base + 7);
        rst = 1'b1;
        #1;
        check_idle("midreset");
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        base = beats_seen;
        send_slice({4'h9, 3'd5, 57'h1_2345_6789_ABCD}, 0);
        wait_beats(base + 20);
        chk("queue_empty_after_reset", exp_q.size(), 0);
        repeat (3) @(posedge clk);
        #1;
        check_idle("final");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
